// File: rtl/spart_bus_ctrl.sv
// Bus master that programs the SPART baud divisor after reset, then echoes received bytes through a small FIFO.
// One bus access per state; access/GAP/IDLE cadence gives rda-to-echo-write in 4 cycles; a full FIFO leaves bytes in the SPART.
module spart_bus_ctrl #(
   parameter logic [15:0] DIV_4800   = 16'h0515,
   parameter logic [15:0] DIV_9600   = 16'h028A,
   parameter logic [15:0] DIV_19200  = 16'h0145,
   parameter logic [15:0] DIV_38400  = 16'h00A2,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       cfg_done,
   output logic [2:0] fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, GAP} state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [1:0]    br_cfg_q;
   logic [1:0]    cfg_sel;
   logic [15:0]   div;
   logic [7:0]    dout;
   logic          rr_last;
   logic          reconfig_pend;
   logic          chg;
   logic          can_rd;
   logic          can_wr;
   logic          do_rd;
   logic          do_wr;

   // A change seen on the same edge that launches CFG_LO must already use the new divisor.
   assign chg     = (state != CFG_LO) && (state != CFG_HI) && (br_cfg != br_cfg_q);
   assign cfg_sel = chg ? br_cfg : br_cfg_q;

   always_comb begin
      div = DIV_38400;
      case (cfg_sel)
         2'b00:   div = DIV_4800;
         2'b01:   div = DIV_9600;
         2'b10:   div = DIV_19200;
         default: div = DIV_38400;
      endcase
   end

   assign can_rd  = rda && (fifo_count < 3'(FIFO_DEPTH));
   assign can_wr  = tbr && (fifo_count != 3'd0);
   assign do_rd   = can_rd && (!can_wr || rr_last);
   assign do_wr   = can_wr && !do_rd;

   assign databus = (iocs && !iorw) ? dout : 8'bz;

   always_ff @(posedge clk) begin
      if (state == RD)
         mem[wr_ptr] <= databus;
   end

   // rr_last: 0 = last echo op was a read, 1 = a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= CFG_LO;
         iocs          <= 1'b0;
         iorw          <= 1'b1;
         ioaddr        <= 2'b00;
         dout          <= 8'h00;
         cfg_done      <= 1'b0;
         fifo_count    <= 3'd0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         rr_last       <= 1'b0;
         reconfig_pend <= 1'b0;
         br_cfg_q      <= br_cfg;
      end else begin
         iocs   <= 1'b0;
         iorw   <= 1'b1;
         ioaddr <= 2'b00;
         if (chg) begin
            reconfig_pend <= 1'b1;
            cfg_done      <= 1'b0;
            br_cfg_q      <= br_cfg;
         end
         case (state)
            CFG_LO: begin
               iocs <= 1'b1;
               iorw <= 1'b0;
               // iocs low here only in the first cycle out of reset: launch the low byte first.
               if (!iocs) begin
                  ioaddr <= 2'b10;
                  dout   <= div[7:0];
               end else begin
                  ioaddr <= 2'b11;
                  dout   <= div[15:8];
                  state  <= CFG_HI;
               end
            end
            CFG_HI: begin
               cfg_done <= 1'b1;
               state    <= GAP;
            end
            GAP: begin
               if (reconfig_pend || chg) begin
                  iocs          <= 1'b1;
                  iorw          <= 1'b0;
                  ioaddr        <= 2'b10;
                  dout          <= div[7:0];
                  reconfig_pend <= 1'b0;
                  state         <= CFG_LO;
               end else begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (reconfig_pend || chg) begin
                  state <= GAP;
               end else if (do_rd) begin
                  iocs  <= 1'b1;
                  state <= RD;
               end else if (do_wr) begin
                  iocs  <= 1'b1;
                  iorw  <= 1'b0;
                  dout  <= mem[rd_ptr];
                  state <= WR;
               end
            end
            RD: begin
               wr_ptr     <= wr_ptr + 1'b1;
               fifo_count <= fifo_count + 1'b1;
               rr_last    <= 1'b0;
               state      <= GAP;
            end
            WR: begin
               rd_ptr     <= rd_ptr + 1'b1;
               fifo_count <= fifo_count - 1'b1;
               rr_last    <= 1'b1;
               state      <= GAP;
            end
            default: state <= GAP;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: SPART model on the bus, echo scoreboard, table of divisor programming vectors.
module tb_spart_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   logic       rda;
   logic       tbr;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       cfg_done;
   logic [2:0] fifo_count;

   logic       drv;
   logic [7:0] drv_dat;

   assign databus = drv ? drv_dat : 8'bz;
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup pu (databus[i]);
   end

   always #5 clk = ~clk;

   spart_bus_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_count (fifo_count)
   );

   typedef struct {
      logic [1:0] cfg;
      logic [7:0] lo;
      logic [7:0] hi;
   } cfg_vec_t;

   cfg_vec_t   tv [4];
   int         n_cmp   = 0;
   int         n_bad   = 0;
   int         cyc     = 0;
   int         rd_seen = 0;
   int         wr_seen = 0;
   int         rd_cyc  = 0;
   int         wr_cyc  = 0;
   logic [7:0] rx_q  [$];
   logic [7:0] exp_q [$];
   logic       acc_log [$];
   logic       prev_iocs = 1'b0;
   logic [1:0] prev_addr = 2'b00;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One clock: SPART model answers reads, scoreboard checks echo writes, bus rules checked every cycle.
   task automatic step();
      @(negedge clk);
      drv = 1'b0;
      #1;
      cyc++;
      if (!iocs) chk("bus_released_idle", 16'(databus), 16'h00FF);
      chk("back_to_back_iocs", 16'(iocs && prev_iocs && !(prev_addr == 2'b10 && ioaddr == 2'b11)), 16'd0);
      if (iocs && ioaddr == 2'b00) begin
         acc_log.push_back(iorw);
         if (iorw) begin
            chk("rd_bus_released", 16'(databus), 16'h00FF);
            chk("rd_data_avail", 16'(rx_q.size() != 0), 16'd1);
            rd_seen++;
            rd_cyc  = cyc;
            drv_dat = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
            drv     = 1'b1;
         end else begin
            wr_seen++;
            wr_cyc = cyc;
            chk("write_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) chk("echo_data", 16'(databus), 16'(exp_q.pop_front()));
         end
      end
      prev_iocs = iocs;
      prev_addr = ioaddr;
      rda = (rx_q.size() != 0);
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_q.push_back(b);
      exp_q.push_back(b);
      rda = 1'b1;
   endtask

   task automatic wait_rd(input int target, input string nm);
      for (int k = 0; k < 60 && rd_seen < target; k++) step();
      chk(nm, 16'(rd_seen >= target), 16'd1);
   endtask

   task automatic wait_wr(input int target, input string nm);
      for (int k = 0; k < 60 && wr_seen < target; k++) step();
      chk(nm, 16'(wr_seen >= target), 16'd1);
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
      chk(nm, 16'(exp_q.size()), 16'd0);
      step();
   endtask

   initial begin
      logic rr_exp [4];
      int   t;
      rr_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst = 1'b0; rda = 1'b0; tbr = 1'b0; br_cfg = 2'b00; drv = 1'b0; drv_dat = 8'h00;
      tv[0] = '{2'b00, 8'h15, 8'h05};
      tv[1] = '{2'b10, 8'h45, 8'h01};
      tv[2] = '{2'b11, 8'hA2, 8'h00};
      tv[3] = '{2'b01, 8'h8A, 8'h02};

      // Divisor programming for every baud select, ending with 9600.
      for (int i = 0; i < 4; i++) begin
         rst = 1'b0; br_cfg = tv[i].cfg;
         step(); step();
         chk("rst_iocs", 16'(iocs), 16'd0);
         chk("rst_iorw", 16'(iorw), 16'd1);
         chk("rst_addr", 16'(ioaddr), 16'd0);
         chk("rst_cfg_done", 16'(cfg_done), 16'd0);
         chk("rst_count", 16'(fifo_count), 16'd0);
         rst = 1'b1;
         step();
         chk("lo_iocs", 16'(iocs), 16'd1);
         chk("lo_iorw", 16'(iorw), 16'd0);
         chk("lo_addr", 16'(ioaddr), 16'd2);
         chk("lo_data", 16'(databus), 16'(tv[i].lo));
         chk("lo_cfg_done", 16'(cfg_done), 16'd0);
         step();
         chk("hi_iocs", 16'(iocs), 16'd1);
         chk("hi_addr", 16'(ioaddr), 16'd3);
         chk("hi_data", 16'(databus), 16'(tv[i].hi));
         step();
         chk("cfg_done", 16'(cfg_done), 16'd1);
         chk("post_cfg_iocs", 16'(iocs), 16'd0);
         step(); step();
         chk("idle_no_access", 16'(iocs), 16'd0);
      end

      // Single byte echo: RD, then WR three cycles later.
      tbr = 1'b1;
      push_rx(8'h41);
      t = rd_seen + 1; wait_rd(t, "echo_rd_seen");
      step();
      chk("count_after_rd", 16'(fifo_count), 16'd1);
      t = wr_seen + 1; wait_wr(t, "echo_wr_seen");
      chk("rd_to_wr_cycles", 16'(wr_cyc - rd_cyc), 16'd3);
      step();
      chk("count_after_wr", 16'(fifo_count), 16'd0);

      // Fill to full with tbr low, then drain with round-robin interleave.
      tbr = 1'b0;
      for (int b = 0; b < 6; b++) push_rx(8'h10 + 8'(b));
      t = rd_seen;
      for (int k = 0; k < 60; k++) step();
      chk("full_reads", 16'(rd_seen - t), 16'd4);
      chk("full_count", 16'(fifo_count), 16'd4);
      chk("full_left_in_spart", 16'(rx_q.size()), 16'd2);
      acc_log.delete();
      tbr = 1'b1;
      drain("full_drain");
      for (int k = 0; k < 4; k++) chk("rr_interleave", 16'(acc_log[k]), 16'(rr_exp[k]));
      chk("drained_count", 16'(fifo_count), 16'd0);

      // count=2 with last op a read: WR wins, then RD.
      tbr = 1'b0;
      push_rx(8'h20); push_rx(8'h21);
      t = rd_seen + 2; wait_rd(t, "two_reads");
      step(); step(); step();
      chk("count_two", 16'(fifo_count), 16'd2);
      acc_log.delete();
      push_rx(8'h22);
      tbr = 1'b1;
      for (int k = 0; k < 40 && acc_log.size() < 2; k++) step();
      chk("rr_first_wr", 16'(acc_log[0]), 16'd0);
      chk("rr_then_rd", 16'(acc_log[1]), 16'd1);
      drain("rr_drain");
      chk("rr_count", 16'(fifo_count), 16'd0);

      // Baud change during a read: finish access, GAP, reprogram, keep FIFO.
      tbr = 1'b0;
      push_rx(8'h30); push_rx(8'h31);
      t = rd_seen + 2; wait_rd(t, "rc_fill");
      push_rx(8'h32);
      t = rd_seen + 1; wait_rd(t, "rc_rd");
      br_cfg = 2'b11;
      step();
      chk("rc_gap_iocs", 16'(iocs), 16'd0);
      chk("rc_cfg_done_low", 16'(cfg_done), 16'd0);
      chk("rc_count", 16'(fifo_count), 16'd3);
      step();
      chk("rc_lo_iocs", 16'(iocs), 16'd1);
      chk("rc_lo_addr", 16'(ioaddr), 16'd2);
      chk("rc_lo_data", 16'(databus), 16'h00A2);
      chk("rc_lo_cfg_done", 16'(cfg_done), 16'd0);
      step();
      chk("rc_hi_addr", 16'(ioaddr), 16'd3);
      chk("rc_hi_data", 16'(databus), 16'h0000);
      chk("rc_hi_cfg_done", 16'(cfg_done), 16'd0);
      step();
      chk("rc_cfg_done", 16'(cfg_done), 16'd1);
      chk("rc_count_kept", 16'(fifo_count), 16'd3);
      tbr = 1'b1;
      drain("rc_drain");
      chk("rc_count_end", 16'(fifo_count), 16'd0);

      // Reset asserted in the middle of a WR cycle.
      tbr = 1'b0;
      push_rx(8'h40); push_rx(8'h41);
      t = rd_seen + 2; wait_rd(t, "mr_fill");
      tbr = 1'b1;
      t = wr_seen + 1; wait_wr(t, "mr_wr");
      rst = 1'b0;
      #1;
      chk("mr_iocs", 16'(iocs), 16'd0);
      chk("mr_bus", 16'(databus), 16'h00FF);
      chk("mr_count", 16'(fifo_count), 16'd0);
      chk("mr_cfg_done", 16'(cfg_done), 16'd0);
      exp_q.delete(); rx_q.delete();
      rda = 1'b0; tbr = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      chk("mr_lo_addr", 16'(ioaddr), 16'd2);
      chk("mr_lo_data", 16'(databus), 16'h00A2);
      step();
      chk("mr_hi_addr", 16'(ioaddr), 16'd3);
      step();
      chk("mr_cfg_done", 16'(cfg_done), 16'd1);

      chk("sb_empty", 16'(exp_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
